// File: rtl/gas_detector_sensor_pkg.sv
// Shared constants and the level update rule for the gas detector.
package gas_detector_sensor_pkg;

  localparam int unsigned DOUT_W               = 3;
  localparam logic [DOUT_W-1:0] DOUT_MAX       = 3'd7;
  localparam int unsigned DECAY_CYCLES_DEFAULT = 8;
  localparam int unsigned SYNC_STAGES_DEFAULT  = 2;

  // Saturating one-step level update; increment wins over decrement.
  function automatic logic [DOUT_W-1:0] level_next(input logic [DOUT_W-1:0] level,
                                                   input logic              inc,
                                                   input logic              dec);
    logic [DOUT_W-1:0] nxt;
    nxt = level;
    if (inc) begin
      if (level != DOUT_MAX) nxt = level + DOUT_W'(1);
    end else if (dec) begin
      if (level != '0) nxt = level - DOUT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gas_detector_sensor_pulse_sync_edge.sv
// Synchronizes the raw sensor line and flags each 0->1 transition for one cycle.
module pulse_sync_edge
  import gas_detector_sensor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic arst,
  input  logic din_async,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // Tracks which flops hold real samples since reset; the extra top bit covers prev_q.
  logic [SYNC_STAGES:0]   vld_q;

  // Synchronizer chain, previous-value flop and sample-validity tracker.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // A reset-value 0 in prev_q is not an observed low, so no edge is reported until it is real.
  always_comb begin
    pulse = sync_q[SYNC_STAGES-1] & ~prev_q & vld_q[SYNC_STAGES];
  end

endmodule

// File: rtl/gas_detector_sensor.sv
// Gas severity level: rises by one per sensor pulse, decays by one after a quiet period.
module gas_detector_sensor
  import gas_detector_sensor_pkg::*;
#(
  parameter int unsigned DECAY_CYCLES = DECAY_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              din,
  output logic [DOUT_W-1:0] dout
);

  localparam int unsigned IdleW = $clog2(DECAY_CYCLES);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(DECAY_CYCLES - 1);

  logic              pulse;
  logic              decay;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [DOUT_W-1:0] dout_q, dout_d;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .arst     (arst),
    .din_async(din),
    .pulse    (pulse)
  );

  // Idle counter and level next-state; a pulse clears the count and preempts decay.
  always_comb begin
    idle_d = idle_q + IdleW'(1);
    decay  = 1'b0;
    if (pulse) begin
      idle_d = '0;
    end else if (idle_q == IdleLast) begin
      idle_d = '0;
      decay  = 1'b1;
    end
    dout_d = level_next(dout_q, pulse, decay);
  end

  // Level and idle counter registers.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      idle_q <= '0;
      dout_q <= '0;
    end else begin
      idle_q <= idle_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_gas_detector_sensor.sv
// Directed, table-driven bench for gas_detector_sensor (default parameters).
module tb_gas_detector_sensor;

  logic       clk = 1'b0;
  logic       arst;
  logic       din;
  logic [2:0] dout;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       arst;
    logic       din;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  gas_detector_sensor dut (
    .clk (clk),
    .arst(arst),
    .din (din),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic a, input logic d, input int n, input logic [2:0] e);
    vec_t v;
    v.arst = a;
    v.din  = d;
    v.exp  = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dout=%0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the following rising edge.
  task automatic step(input logic a, input logic d, input logic [2:0] e, input string name);
    @(negedge clk);
    arst = a;
    din  = d;
    @(posedge clk);
    #1;
    check(name, dout, e);
  endtask

  initial begin
    int lvl;
    arst = 1'b0;
    din  = 1'b1;

    // Reset with din high, then release with din still high: no event.
    add(0, 1, 2, 0);
    add(1, 1, 6, 0);            // edges 1..6
    add(1, 0, 4, 0);            // edges 7..10
    // Three single-cycle pulses 6 apart, each visible two edges after sampling.
    add(1, 1, 1, 0);            // 11
    add(1, 0, 1, 0);            // 12
    add(1, 0, 4, 1);            // 13..16
    add(1, 1, 1, 1);            // 17
    add(1, 0, 1, 1);            // 18
    add(1, 0, 4, 2);            // 19..22
    add(1, 1, 1, 2);            // 23
    add(1, 0, 1, 2);            // 24
    add(1, 0, 1, 3);            // 25
    // Quiet line: decay every 8 cycles down to 0, then hold.
    add(1, 0, 7, 3);            // 26..32
    add(1, 0, 8, 2);            // 33..40
    add(1, 0, 8, 1);            // 41..48
    add(1, 0, 10, 0);           // 49..58
    // Pulse landing exactly on a decay point must increment.
    add(1, 0, 2, 0);            // 59..60
    add(1, 1, 1, 0);            // 61
    add(1, 0, 1, 0);            // 62
    add(1, 0, 6, 1);            // 63..68
    add(1, 1, 1, 1);            // 69
    add(1, 0, 1, 1);            // 70
    add(1, 0, 1, 2);            // 71
    add(1, 0, 7, 2);            // 72..78
    add(1, 0, 1, 1);            // 79
    // Ten pulses 3 apart: climb to 7 and saturate.
    lvl = 1;
    for (int k = 0; k < 10; k++) begin
      add(1, 1, 1, 3'(lvl));
      add(1, 0, 1, 3'(lvl));
      if (lvl < 7) lvl++;
      add(1, 0, 1, 3'(lvl));
    end                         // 80..109
    add(1, 0, 7, 7);            // 110..116
    add(1, 0, 1, 6);            // 117
    add(1, 0, 7, 6);            // 118..124
    add(1, 0, 1, 5);            // 125

    foreach (vecs[i]) step(vecs[i].arst, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

    // Pending event then asynchronous reset mid-cycle while dout=5.
    step(1, 1, 5, "pend_sample");
    #2;
    arst = 1'b0;
    #1;
    check("async_rst", dout, 3'd0);
    step(0, 0, 0, "rst_hold0");
    step(0, 0, 0, "rst_hold1");
    // Release with din low, then a fresh pulse takes the normal two edges.
    step(1, 0, 0, "rel0");
    step(1, 0, 0, "rel1");
    step(1, 0, 0, "rel2");
    step(1, 1, 0, "post_pulse_n");
    step(1, 0, 0, "post_pulse_n1");
    step(1, 0, 1, "post_pulse_n2");
    for (int k = 0; k < 7; k++) step(1, 0, 1, $sformatf("post_idle%0d", k));
    step(1, 0, 0, "post_decay");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gas_detector_sensor.md
GAS_DETECTOR_SENSOR -- requirements
Module: gas_detector_sensor

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset; no other clock or reset SHALL exist.
REQ-002 Parameter DECAY_CYCLES, default 8, SHALL set the number of consecutive pulse-free cycles before dout decays by one (legal range 2..256).
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the number of din synchronizer flops (legal range 2..4).
REQ-004 Port clk  input  1  SHALL be the rising-edge clock for all state.
REQ-005 Port arst  input  1  SHALL be the asynchronous active-low reset (0 = reset).
REQ-006 Port din  input  1  SHALL be the raw, asynchronous gas-sensor pulse line.
REQ-007 Port dout  output  3  SHALL be the gas severity level, 0 (clean) to 7 (maximum), driven directly from a register.

Function
REQ-008 din SHALL pass through a SYNC_STAGES-deep flop chain; a further flop SHALL hold the previous synchronized value.
REQ-009 A pulse event SHALL be asserted for exactly one cycle when the synchronized din is 1 and its previous value is 0; din held high SHALL count as one event only.
REQ-010 On a pulse event, dout SHALL increment by 1 at the next rising edge, saturating at 7.
REQ-011 With default SYNC_STAGES, din first sampled high at edge N SHALL make dout increment at edge N+2.
REQ-012 An idle counter SHALL count cycles without a pulse event and SHALL clear to 0 on every pulse event.
REQ-013 When the idle counter reaches DECAY_CYCLES-1 without a pulse event and dout>0, dout SHALL decrement by 1 at that edge and the idle counter SHALL clear.
REQ-014 When the idle counter reaches DECAY_CYCLES-1 and dout=0, dout SHALL stay 0 and the idle counter SHALL clear.
REQ-015 A pulse event coinciding with a decay point SHALL take priority: dout increments (or holds at 7) and no decrement occurs.
REQ-016 A pulse event at dout=7 SHALL hold dout at 7 and clear the idle counter.
REQ-017 dout SHALL never wrap: no transition 7->0 or 0->7.
REQ-018 dout SHALL change by at most 1 per clock cycle.

Reset
REQ-019 While arst=0, all synchronizer flops, the edge flop, the idle counter and dout SHALL be 0 immediately, regardless of clk.
REQ-020 Reset deassertion SHALL create no pulse event, even if din is 1 at that time; an event requires a 0 then 1 transition in the synchronized din.
REQ-021 Reset asserted mid-operation SHALL discard any pending event and the idle count.

Structure
REQ-022 The shared package SHALL hold the constants DOUT_W=3, DOUT_MAX=7 and the default DECAY_CYCLES.
REQ-023 The synchronizer plus rising-edge detector SHALL be one sub-module, pulse_sync_edge (ports clk, arst, din_async, pulse).
REQ-024 The level and idle-counter logic SHALL reside in the top module; there SHALL be no other sub-modules.

Verification
REQ-025 arst=0 pulse, with din=1 held across deassertion -> dout=0 and no increment.
REQ-026 Three 1-cycle din pulses spaced 6 cycles apart -> dout sequence 1,2,3, with each step at edge N+2 after the pulse is sampled.
REQ-027 Ten pulses spaced 3 cycles apart -> dout climbs to 7 and holds at 7 with no wrap.
REQ-028 dout=3, then din held 0 for 24 cycles -> decrements every 8 cycles to 2, 1, 0, then holds at 0.
REQ-029 A pulse timed to land on the 8th idle cycle -> dout increments and no decrement occurs.
REQ-030 arst asserted asynchronously mid-clock while dout=5 -> dout=0 before the next clk edge.
